// File: rtl/chain_latency_monitor_if.sv
// Signal bundle between the delay-chain stress bench and chain_latency_monitor.
// master drives the launch/capture nets and clear; slave is the monitor.
interface chain_latency_monitor_if #(
   parameter int unsigned FIFO_DEPTH = 16,
   parameter int unsigned TS_W       = 24,
   parameter int unsigned CNT_W      = 32
);
   logic                          launch;
   logic                          capture;
   logic                          clear;
   logic                          lat_valid;
   logic [TS_W-1:0]               lat_value;
   logic [TS_W-1:0]               lat_min;
   logic [TS_W-1:0]               lat_max;
   logic [CNT_W-1:0]              edge_cnt;
   logic [$clog2(FIFO_DEPTH):0]   pending;
   logic                          overflow;
   logic                          spurious;
   logic                          timeout;

   modport master (
      output launch, capture, clear,
      input  lat_valid, lat_value, lat_min, lat_max, edge_cnt, pending,
             overflow, spurious, timeout
   );

   modport slave (
      input  launch, capture, clear,
      output lat_valid, lat_value, lat_min, lat_max, edge_cnt, pending,
             overflow, spurious, timeout
   );
endinterface

// File: rtl/chain_latency_monitor.sv
// Far-end checker for a toggle-stimulus delay chain: timestamps launch edges, matches capture
// edges in FIFO order, reports latency stats. Optional lost-edge timeout via MON_TIMEOUT_EN.
module chain_latency_monitor #(
   parameter int unsigned FIFO_DEPTH  = 16,
   parameter int unsigned TS_W        = 24,
   parameter int unsigned CNT_W       = 32,
   parameter int unsigned TIMEOUT_CYC = 4096
) (
   input logic                    clk,
   input logic                    rst,
   chain_latency_monitor_if.slave mon
);
   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam int unsigned CW = AW + 1;
`ifdef MON_TIMEOUT_EN
   localparam bit TIMEOUT_EN = 1'b1;
`else
   localparam bit TIMEOUT_EN = 1'b0;
`endif

   typedef enum logic [1:0] {StEmpty, StTracking, StFault} state_e;

   state_e            state_q, state_d;
   logic [TS_W-1:0]   ts_q;
   logic              launch_q, capture_q;
   logic [TS_W-1:0]   mem_q [FIFO_DEPTH];
   logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]     count_q, count_d;
   logic              lat_valid_q;
   logic [TS_W-1:0]   lat_value_q, lat_min_q, lat_max_q;
   logic [CNT_W-1:0]  edge_cnt_q;
   logic              overflow_q, spurious_q, timeout_q;

   logic              l_edge, c_edge, active, empty, full;
   logic              do_push, do_pop, spur, ovf, tmo;
   logic [TS_W-1:0]   head, lat;

   always_comb begin
      l_edge  = mon.launch ^ launch_q;
      c_edge  = mon.capture ^ capture_q;
      active  = (state_q != StFault);
      empty   = (count_q == '0);
      full    = (count_q == CW'(FIFO_DEPTH));
      head    = mem_q[rd_ptr_q];
      // Modular difference stays correct across ts wrap for latencies below 2^TS_W.
      lat     = ts_q - head;
      do_pop  = active && c_edge && !empty;
      do_push = active && l_edge && (!full || do_pop);
      spur    = active && c_edge && empty;
      ovf     = active && l_edge && full && !do_pop;
      tmo     = TIMEOUT_EN && (state_q == StTracking) && (lat >= TS_W'(TIMEOUT_CYC));
      count_d = count_q + CW'(do_push) - CW'(do_pop);

      state_d = state_q;
      unique case (state_q)
         StEmpty:    if (do_push) state_d = StTracking;
         StTracking: if (count_d == '0) state_d = StEmpty;
         StFault:    state_d = StFault;
         default:    state_d = StEmpty;
      endcase
      if (spur || ovf || tmo) state_d = StFault;
   end

   always_ff @(posedge clk) begin
      if (!rst && !mon.clear && do_push) mem_q[wr_ptr_q] <= ts_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ts_q        <= '0;
         launch_q    <= 1'b0;
         capture_q   <= 1'b0;
         state_q     <= StEmpty;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         lat_valid_q <= 1'b0;
         lat_value_q <= '0;
         lat_min_q   <= '1;
         lat_max_q   <= '0;
         edge_cnt_q  <= '0;
         overflow_q  <= 1'b0;
         spurious_q  <= 1'b0;
         timeout_q   <= 1'b0;
      end else begin
         ts_q <= ts_q + TS_W'(1);
         if (mon.clear) begin
            launch_q    <= 1'b0;
            capture_q   <= 1'b0;
            state_q     <= StEmpty;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            lat_valid_q <= 1'b0;
            lat_value_q <= '0;
            lat_min_q   <= '1;
            lat_max_q   <= '0;
            edge_cnt_q  <= '0;
            overflow_q  <= 1'b0;
            spurious_q  <= 1'b0;
            timeout_q   <= 1'b0;
         end else begin
            launch_q    <= mon.launch;
            capture_q   <= mon.capture;
            state_q     <= state_d;
            count_q     <= count_d;
            lat_valid_q <= do_pop;
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop) begin
               rd_ptr_q    <= rd_ptr_q + AW'(1);
               lat_value_q <= lat;
               if (lat < lat_min_q) lat_min_q <= lat;
               if (lat > lat_max_q) lat_max_q <= lat;
               if (edge_cnt_q != '1) edge_cnt_q <= edge_cnt_q + CNT_W'(1);
            end
            if (ovf)  overflow_q <= 1'b1;
            if (spur) spurious_q <= 1'b1;
            if (tmo)  timeout_q  <= 1'b1;
         end
      end
   end

   assign mon.lat_valid = lat_valid_q;
   assign mon.lat_value = lat_value_q;
   assign mon.lat_min   = lat_min_q;
   assign mon.lat_max   = lat_max_q;
   assign mon.edge_cnt  = edge_cnt_q;
   assign mon.pending   = count_q;
   assign mon.overflow  = overflow_q;
   assign mon.spurious  = spurious_q;
   assign mon.timeout   = timeout_q;
endmodule

// File: tb/tb_chain_latency_monitor.sv
// Self-checking bench for chain_latency_monitor: directed cases plus random toggle traffic
// compared against a queue-based reference model. Honours MON_TIMEOUT_EN like the design.
module tb_chain_latency_monitor;
   localparam int unsigned FIFO_DEPTH  = 16;
   localparam int unsigned TS_W        = 24;
   localparam int unsigned CNT_W       = 32;
   localparam int unsigned TIMEOUT_CYC = 4096;
`ifdef MON_TIMEOUT_EN
   localparam bit TIMEOUT_EN = 1'b1;
`else
   localparam bit TIMEOUT_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;

   chain_latency_monitor_if #(.FIFO_DEPTH(FIFO_DEPTH), .TS_W(TS_W), .CNT_W(CNT_W)) bus ();

   chain_latency_monitor #(
      .FIFO_DEPTH (FIFO_DEPTH),
      .TS_W       (TS_W),
      .CNT_W      (CNT_W),
      .TIMEOUT_CYC(TIMEOUT_CYC)
   ) dut (
      .clk(clk),
      .rst(rst),
      .mon(bus)
   );

   always #5 clk = ~clk;

   int unsigned passed = 0;
   int unsigned total  = 0;

   // Reference model: a queue of launch timestamps and the externally visible results.
   logic [TS_W-1:0]  q[$];
   logic [TS_W-1:0]  m_ts;
   bit               m_lq, m_cq, m_fault;
   bit               e_lat_valid, e_ovf, e_spur, e_tmo;
   logic [TS_W-1:0]  e_lat_value, e_min, e_max;
   logic [CNT_W-1:0] e_cnt;
   bit               cur_l, cur_c;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic model_clear(input bit keep_ts);
      q.delete();
      if (!keep_ts) m_ts = '0;
      m_lq = 0; m_cq = 0; m_fault = 0;
      e_lat_valid = 0; e_ovf = 0; e_spur = 0; e_tmo = 0;
      e_lat_value = '0; e_min = '1; e_max = '0; e_cnt = '0;
   endtask

   task automatic model_cycle(input bit l, input bit c, input bit clr);
      bit le, ce, fault_now;
      logic [TS_W-1:0] lat;
      if (clr) begin
         model_clear(1'b1);
         m_ts = m_ts + 1'b1;
         return;
      end
      le = l ^ m_lq;
      ce = c ^ m_cq;
      m_lq = l;
      m_cq = c;
      e_lat_valid = 0;
      if (!m_fault) begin
         fault_now = 0;
         if (TIMEOUT_EN && q.size() > 0 && (m_ts - q[0]) >= TS_W'(TIMEOUT_CYC)) begin
            e_tmo = 1; fault_now = 1;
         end
         if (ce) begin
            if (q.size() == 0) begin
               e_spur = 1; fault_now = 1;
            end else begin
               lat = m_ts - q.pop_front();
               e_lat_valid = 1;
               e_lat_value = lat;
               if (lat < e_min) e_min = lat;
               if (lat > e_max) e_max = lat;
               if (e_cnt != '1) e_cnt = e_cnt + 1'b1;
            end
         end
         if (le) begin
            if (q.size() < FIFO_DEPTH) q.push_back(m_ts);
            else begin
               e_ovf = 1; fault_now = 1;
            end
         end
         if (fault_now) m_fault = 1;
      end
      m_ts = m_ts + 1'b1;
   endtask

   task automatic check_outputs(input string tag);
      chk({tag, ".lat_valid"}, 64'(bus.lat_valid), 64'(e_lat_valid));
      chk({tag, ".lat_value"}, 64'(bus.lat_value), 64'(e_lat_value));
      chk({tag, ".lat_min"},   64'(bus.lat_min),   64'(e_min));
      chk({tag, ".lat_max"},   64'(bus.lat_max),   64'(e_max));
      chk({tag, ".edge_cnt"},  64'(bus.edge_cnt),  64'(e_cnt));
      chk({tag, ".pending"},   64'(bus.pending),   64'(q.size()));
      chk({tag, ".overflow"},  64'(bus.overflow),  64'(e_ovf));
      chk({tag, ".spurious"},  64'(bus.spurious),  64'(e_spur));
      chk({tag, ".timeout"},   64'(bus.timeout),   64'(e_tmo));
   endtask

   // One clock cycle: drive inputs at negedge, advance model, check after posedge.
   task automatic step(input bit l, input bit c, input bit clr, input string tag);
      @(negedge clk);
      bus.launch  = l;
      bus.capture = c;
      bus.clear   = clr;
      cur_l = l;
      cur_c = c;
      model_cycle(l, c, clr);
      @(posedge clk);
      #1;
      check_outputs(tag);
   endtask

   task automatic idle(input int n, input string tag);
      for (int i = 0; i < n; i++) step(cur_l, cur_c, 1'b0, tag);
   endtask

   task automatic do_clear(input string tag);
      step(1'b0, 1'b0, 1'b1, tag);
      step(1'b0, 1'b0, 1'b0, tag);
   endtask

   initial begin
      bus.launch = 0; bus.capture = 0; bus.clear = 0;
      cur_l = 0; cur_c = 0;
      model_clear(1'b0);
      repeat (2) @(posedge clk);
      #1;
      check_outputs("reset");
      chk("reset.lat_min_ones", 64'(bus.lat_min), 64'h00FF_FFFF);
      rst = 1'b0;

      // Single edge: launch at cycle 10, capture at cycle 47.
      idle(10, "t2");
      step(1'b1, 1'b0, 1'b0, "t2.launch");
      idle(36, "t2");
      chk("t2.pending_before", 64'(bus.pending), 64'd1);
      step(1'b1, 1'b1, 1'b0, "t2.capture");
      chk("t2.lat_valid", 64'(bus.lat_valid), 64'd1);
      chk("t2.lat_value", 64'(bus.lat_value), 64'd37);
      chk("t2.min", 64'(bus.lat_min), 64'd37);
      chk("t2.max", 64'(bus.lat_max), 64'd37);
      chk("t2.cnt", 64'(bus.edge_cnt), 64'd1);
      chk("t2.pending_after", 64'(bus.pending), 64'd0);
      step(1'b1, 1'b1, 1'b0, "t2.pulse_end");
      chk("t2.lat_valid_drop", 64'(bus.lat_valid), 64'd0);

      // Three in-flight edges: launches at 0,5,9, captures at 20,30,31.
      do_clear("t3.clr");
      for (int r = 0; r < 32; r++) begin
         bit tl, tc;
         tl = (r == 0 || r == 5 || r == 9);
         tc = (r == 20 || r == 30 || r == 31);
         step(cur_l ^ tl, cur_c ^ tc, 1'b0, "t3");
      end
      chk("t3.last_lat", 64'(bus.lat_value), 64'd22);
      chk("t3.min", 64'(bus.lat_min), 64'd20);
      chk("t3.max", 64'(bus.lat_max), 64'd25);
      chk("t3.cnt", 64'(bus.edge_cnt), 64'd3);

      // Overflow: 17 launches with no capture.
      do_clear("t4.clr");
      for (int i = 0; i < 17; i++) begin
         step(~cur_l, cur_c, 1'b0, "t4.launch");
         if (i == 15) chk("t4.full_no_ovf", 64'(bus.overflow), 64'd0);
         step(cur_l, cur_c, 1'b0, "t4.gap");
      end
      chk("t4.overflow", 64'(bus.overflow), 64'd1);
      chk("t4.pending", 64'(bus.pending), 64'd16);
      for (int i = 0; i < 3; i++) begin
         step(cur_l, ~cur_c, 1'b0, "t4.cap");
         chk("t4.no_lat_valid", 64'(bus.lat_valid), 64'd0);
      end
      chk("t4.pending_frozen", 64'(bus.pending), 64'd16);
      do_clear("t4.clr2");
      chk("t4.clr_overflow", 64'(bus.overflow), 64'd0);
      chk("t4.clr_pending", 64'(bus.pending), 64'd0);

      // Spurious capture with nothing pending.
      step(cur_l, ~cur_c, 1'b0, "t5.cap");
      chk("t5.spurious", 64'(bus.spurious), 64'd1);
      chk("t5.cnt", 64'(bus.edge_cnt), 64'd0);
      do_clear("t5.clr");

      // Async reset mid-flight discards pending entries.
      step(1'b1, 1'b0, 1'b0, "t1.launch");
      idle(3, "t1");
      rst = 1'b1;
      #1;
      bus.launch = 0; bus.capture = 0; cur_l = 0; cur_c = 0;
      model_clear(1'b0);
      check_outputs("t1.rst");
      chk("t1.lat_min_ones", 64'(bus.lat_min), 64'h00FF_FFFF);
      rst = 1'b0;

      // Random toggle traffic.
      for (int i = 0; i < 3000; i++) begin
         bit tl, tc;
         if ((m_fault && $urandom_range(7) == 0) || $urandom_range(299) == 0) begin
            step(1'b0, 1'b0, 1'b1, "rnd.clr");
         end else begin
            tl = ($urandom_range(9) < 3);
            tc = (q.size() > 0) ? ($urandom_range(9) < 3) : ($urandom_range(49) == 0);
            step(cur_l ^ tl, cur_c ^ tc, 1'b0, "rnd");
         end
      end

      // Lost edge: launch once and never capture.
      do_clear("t6.clr");
      step(~cur_l, cur_c, 1'b0, "t6.launch");
      idle(10000, "t6");
      chk("t6.timeout_final", 64'(bus.timeout), 64'(TIMEOUT_EN));

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
